// File: rtl/io_conv_sequencer.sv
// io_conv_sequencer: feeds ROW rows of a matrix from row memory into io_converter
// and counts slice_done pulses until the matrix is fully sliced, then pulses done.
module io_conv_sequencer #(
  parameter int WIDTH      = 16,
  parameter int COL        = 6,
  parameter int ROW        = 8,
  parameter int NUM_SLICES = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] row_base,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WIDTH*COL-1:0]  mem_rd_data,
  output logic                  conv_en,
  output logic                  conv_in_valid,
  output logic [WIDTH*COL-1:0]  conv_in_data,
  input  logic                  conv_slice_done
);

  localparam int CW = $clog2(ROW + 1);
  localparam int SW = $clog2(NUM_SLICES + 1);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    FIN
  } state_t;

  state_t                state;
  logic [CW-1:0]         row_cnt;
  logic [SW-1:0]         slice_cnt;
  logic [ADDR_WIDTH-1:0] base;

  logic last_row;
  logic all_sliced;

  assign last_row   = row_cnt == CW'(ROW - 1);
  assign all_sliced = slice_cnt == SW'(NUM_SLICES);

  // Reads only while feeding and not backpressured.
  assign mem_rd_en = (state == FEED) && !stall
                     && (row_cnt < CW'(ROW));

  // Modulo 2^ADDR_WIDTH wrap is intentional.
  assign mem_rd_addr = base + ADDR_WIDTH'(row_cnt);

  // Memory holds its output while stalled, so
  // the converter sees the same row again.
  assign conv_in_data = mem_rd_data;
  assign conv_en      = busy && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row_cnt       <= '0;
      slice_cnt     <= '0;
      base          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      conv_in_valid <= 1'b0;
    end else if (abort) begin
      state         <= IDLE;
      row_cnt       <= '0;
      slice_cnt     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      conv_in_valid <= 1'b0;
    end else begin
      // Valid tracks the read one cycle later,
      // frozen under stall with the data.
      if (!stall)
        conv_in_valid <= mem_rd_en;

      if (busy && conv_slice_done) begin
        if (all_sliced)
          err <= 1'b1;
        else
          slice_cnt <= slice_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= FEED;
            base      <= row_base;
            row_cnt   <= '0;
            slice_cnt <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
          end
        end
        FEED: begin
          if (mem_rd_en) begin
            row_cnt <= row_cnt + 1'b1;
            if (last_row)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (all_sliced) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
